// File: rtl/even_step_checker.sv
// Receive-side monitor for the even-stepping run/pause counter: predicts each next sample and flags and counts deviations.
// Optional wrap counter is built only when EVEN_STEP_CHECKER_WRAP_CNT_EN is defined; otherwise wrap_count is tied to 0.
module even_step_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP     = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_MISS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] expected,
  output logic             error,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int unsigned MISS_W = (MAX_MISS < 1) ? 1 : $clog2(MAX_MISS + 1);

  localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'((2 ** WIDTH) - STEP);
  localparam logic [WIDTH-1:0]  STEP_V   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]  LOW_MASK = WIDTH'(STEP - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_prev;
  logic              r_run_d;
  logic [MISS_W-1:0] r_miss;
  logic              r_error;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_legal;
  logic              w_prev_max;
  logic [WIDTH-1:0]  w_expected;
  logic              w_match;
  logic [MISS_W-1:0] w_miss_inc;
  logic              w_checking;
  logic              w_wrap_hit;

  // The MAX case is decoded explicitly so the WIDTH-bit sum never overflows.
  always_comb begin
    w_legal    = (state_in & LOW_MASK) == '0;
    w_prev_max = (r_prev == MAX_V);
    w_expected = r_prev;
    if (r_run_d) begin
      w_expected = w_prev_max ? '0 : r_prev + STEP_V;
    end
    w_match    = (state_in == w_expected);
    w_miss_inc = r_miss + MISS_W'(1);
    w_checking = (r_state == ST_LOCKED) && !clear;
    w_wrap_hit = w_checking && w_match && r_run_d && w_prev_max && (state_in == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_ACQUIRE;
      r_prev    <= '0;
      r_run_d   <= 1'b0;
      r_miss    <= '0;
      r_error   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_run_d <= run;
      r_error <= 1'b0;
      if (clear) begin
        r_state   <= ST_ACQUIRE;
        r_miss    <= '0;
        r_err_cnt <= '0;
      end else begin
        case (r_state)
          ST_ACQUIRE: begin
            if (w_legal) begin
              r_prev  <= state_in;
              r_miss  <= '0;
              r_state <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_prev <= state_in;
              r_miss <= '0;
            end else begin
              r_error <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
              end
              // Reaching the miss limit overrides resync; prev is left as it was.
              if (w_miss_inc >= MISS_MAX) begin
                r_miss  <= w_miss_inc;
                r_state <= ST_FAULT;
              end else if (w_legal) begin
                r_prev <= state_in;
                r_miss <= w_miss_inc;
              end else begin
                r_miss  <= '0;
                r_state <= ST_ACQUIRE;
              end
            end
          end
          ST_FAULT: begin
            r_state <= ST_FAULT;
          end
          default: begin
            r_state <= ST_ACQUIRE;
          end
        endcase
      end
    end
  end

`ifdef EVEN_STEP_CHECKER_WRAP_CNT_EN
  logic [CNT_W-1:0] r_wrap_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrap_cnt <= '0;
    end else if (clear) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap_hit && (r_wrap_cnt != '1)) begin
      r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
    end
  end

  assign wrap_count = r_wrap_cnt;
`else
  logic w_wrap_unused;
  assign w_wrap_unused = w_wrap_hit;
  assign wrap_count    = '0;
`endif

  assign expected  = w_expected;
  assign error     = r_error;
  assign locked    = (r_state == ST_LOCKED);
  assign fault     = (r_state == ST_FAULT);
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_even_step_checker.sv
// Scoreboard bench for even_step_checker: directed samples push expected responses, a monitor pops and compares.
module tb_even_step_checker;

`ifdef EVEN_STEP_CHECKER_WRAP_CNT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       run = 1'b0;
  logic [3:0] state_in = '0;

  logic [3:0] expected;
  logic       error, locked, fault;
  logic [7:0] err_count, wrap_count;

  logic [3:0] s_expected;
  logic       s_error, s_locked, s_fault;
  logic [1:0] s_err_count, s_wrap_count;

  always #5 clk = ~clk;

  even_step_checker dut (
    .clock(clk), .reset(reset), .clear(clear), .run(run), .state_in(state_in),
    .expected(expected), .error(error), .locked(locked), .fault(fault),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  even_step_checker #(.CNT_W(2)) u_sat (
    .clock(clk), .reset(reset), .clear(clear), .run(run), .state_in(state_in),
    .expected(s_expected), .error(s_error), .locked(s_locked), .fault(s_fault),
    .err_count(s_err_count), .wrap_count(s_wrap_count)
  );

  typedef struct {
    bit sel;
    bit chk_exp;
    int ev;
    int e;
    int l;
    int f;
    int ec;
    int wc;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    sel_sat = 1'b0;

  function automatic int wraps(input int n);
    return (WRAP_EN != 0) ? n : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step(input bit rs, input bit cl, input bit r, input int s,
                      input bit ce, input int ev, input int e, input int l,
                      input int f, input int ec, input int wc);
    item_t it;
    @(negedge clk);
    reset    = rs;
    clear    = cl;
    run      = r;
    state_in = 4'(s);
    it.sel = sel_sat; it.chk_exp = ce; it.ev = ev;
    it.e = e; it.l = l; it.f = f; it.ec = ec; it.wc = wc;
    sb.push_back(it);
  endtask

  // Monitor: expected is sampled mid-cycle, registered outputs #1 after the edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.chk_exp) begin
          chk("expected", it.sel ? int'(s_expected) : int'(expected), it.ev);
        end
        @(posedge clk);
        #1;
        if (it.sel) begin
          chk("sat_error",     int'(s_error),      it.e);
          chk("sat_locked",    int'(s_locked),     it.l);
          chk("sat_fault",     int'(s_fault),      it.f);
          chk("sat_err_count", int'(s_err_count),  it.ec);
          chk("sat_wrap_count",int'(s_wrap_count), it.wc);
        end else begin
          chk("error",      int'(error),      it.e);
          chk("locked",     int'(locked),     it.l);
          chk("fault",      int'(fault),      it.f);
          chk("err_count",  int'(err_count),  it.ec);
          chk("wrap_count", int'(wrap_count), it.wc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then acquire on a legal 0 with run low.
    step(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
    step(1, 0, 0, 0,  1, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0,  1, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, 0,  1, 0,  0, 1, 0, 0, 0);

    // Free run through one full wrap.
    step(0, 0, 1, 0,  1, 0,  0, 1, 0, 0, 0);
    for (int v = 2; v <= 14; v += 2) step(0, 0, 1, v, 1, v, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0,  1, 0,  0, 1, 0, 0, wraps(1));
    step(0, 0, 1, 2,  1, 2,  0, 1, 0, 0, wraps(1));

    // Pause at 6 for three cycles, then resume to 8.
    step(0, 0, 1, 4,  1, 4,  0, 1, 0, 0, wraps(1));
    step(0, 0, 0, 6,  1, 6,  0, 1, 0, 0, wraps(1));
    step(0, 0, 0, 6,  1, 6,  0, 1, 0, 0, wraps(1));
    step(0, 0, 0, 6,  1, 6,  0, 1, 0, 0, wraps(1));
    step(0, 0, 1, 6,  1, 6,  0, 1, 0, 0, wraps(1));
    step(0, 0, 1, 8,  1, 8,  0, 1, 0, 0, wraps(1));

    // Single skip 8 -> 12, resync, then continue through a second wrap.
    step(0, 0, 1, 12, 1, 10, 1, 1, 0, 1, wraps(1));
    step(0, 0, 1, 14, 1, 14, 0, 1, 0, 1, wraps(1));
    step(0, 0, 1, 0,  1, 0,  0, 1, 0, 1, wraps(2));
    step(0, 0, 1, 2,  1, 2,  0, 1, 0, 1, wraps(2));

    // Three consecutive legal-but-wrong samples force FAULT, which is sticky.
    step(0, 0, 1, 8,  1, 4,  1, 1, 0, 2, wraps(2));
    step(0, 0, 1, 2,  1, 10, 1, 1, 0, 3, wraps(2));
    step(0, 0, 1, 12, 1, 4,  1, 0, 1, 4, wraps(2));
    step(0, 0, 1, 4,  0, 0,  0, 0, 1, 4, wraps(2));
    step(0, 0, 1, 6,  0, 0,  0, 0, 1, 4, wraps(2));

    // Clear leaves FAULT, zeroes counters, re-acquire skips the illegal 3.
    step(0, 1, 1, 6,  0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 1, 3,  0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 1, 6,  0, 0,  0, 1, 0, 0, 0);
    step(0, 0, 1, 8,  1, 8,  0, 1, 0, 0, 0);

    // Illegal sample while locked: one error, drop to ACQUIRE, no errors there.
    step(0, 0, 1, 3,  1, 10, 1, 0, 0, 1, 0);
    step(0, 0, 1, 5,  0, 0,  0, 0, 0, 1, 0);
    step(0, 0, 1, 7,  0, 0,  0, 0, 0, 1, 0);
    step(0, 0, 1, 10, 0, 0,  0, 1, 0, 1, 0);
    step(0, 0, 1, 12, 1, 12, 0, 1, 0, 1, 0);

    // Saturation on the CNT_W=2 instance: five isolated mismatches with run low.
    step(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
    sel_sat = 1'b1;
    step(0, 0, 0, 0,  1, 0,  0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 2 * k, 1, 2 * (k - 1), 1, 1, 0, (k < 3) ? k : 3, 0);
      step(0, 0, 0, 2 * k, 1, 2 * k,       0, 1, 0, (k < 3) ? k : 3, 0);
    end

    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
